// File: rtl/aes_stream_ctrl_if.sv
// Word-stream handshake bundle for the AES stream controller.
// Plaintext words flow in on s_*, ciphertext words flow out on m_*.
interface aes_stream_ctrl_if;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;

    modport master (
        output s_data,
        output s_valid,
        output m_ready,
        input  s_ready,
        input  m_data,
        input  m_valid,
        input  m_last
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  m_ready,
        output s_ready,
        output m_data,
        output m_valid,
        output m_last
    );
endinterface

// File: rtl/aes_stream_ctrl.sv
// Stream front/back end for a pipelined AES-128 encrypt core.
// Packs 32-bit words into blocks, tags them through the core, buffers and re-serialises.
module aes_stream_ctrl #(
    parameter int CORE_LATENCY = 10,
    parameter int OUT_DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [127:0]     key_in,
    input  logic             key_we,
    output logic             key_ready,
    output logic [127:0]     core_data,
    output logic [127:0]     core_key,
    input  logic [127:0]     core_out,
    aes_stream_ctrl_if.slave bus
);
    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(OUT_DEPTH);
    localparam logic [PW-1:0] PTR_MAX = PW'(OUT_DEPTH - 1);

    logic                  run_q;
    logic [1:0]            wcnt;
    logic [95:0]           hold;
    logic [CORE_LATENCY:0] tags;
    logic [CW-1:0]         outst;
    logic [CW-1:0]         occ;
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [1:0]            wptr;
    logic [127:0]          ob [OUT_DEPTH];
    logic [127:0]          head_blk;

    logic s_acc;
    logic issue;
    logic cap;
    logic m_acc;
    logic pop;
    logic buf_empty;
    logic buf_full;

    assign s_acc     = bus.s_valid & bus.s_ready;
    assign issue     = s_acc & (wcnt == 2'd3);
    assign cap       = tags[CORE_LATENCY];
    assign buf_empty = (occ == '0);
    assign buf_full  = (occ == CNT_MAX);
    assign m_acc     = bus.m_valid & bus.m_ready;
    assign pop       = m_acc & (wptr == 2'd3);
    assign head_blk  = ob[head];

    // The 4th word only goes in when a buffer slot is guaranteed for it.
    assign bus.s_ready = run_q & ((wcnt != 2'd3) | (outst < CNT_MAX));
    assign key_ready   = (wcnt == 2'd0) & (outst == '0);
    assign bus.m_valid = ~buf_empty;
    assign bus.m_last  = ~buf_empty & (wptr == 2'd3);

    // Pick the head block's current word, most significant first.
    always_comb begin
        bus.m_data = '0;
        if (!buf_empty) begin
            unique case (wptr)
                2'd0: bus.m_data = head_blk[127:96];
                2'd1: bus.m_data = head_blk[95:64];
                2'd2: bus.m_data = head_blk[63:32];
                2'd3: bus.m_data = head_blk[31:0];
            endcase
        end
    end

    // Hold off input acceptance until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Key register, only writable while the core is completely idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_key <= '0;
        end else if (key_we && key_ready) begin
            core_key <= key_in;
        end
    end

    // Word assembler: shift in three words, issue on the fourth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt      <= 2'd0;
            hold      <= '0;
            core_data <= '0;
        end else if (s_acc) begin
            wcnt <= wcnt + 2'd1;
            hold <= {hold[63:0], bus.s_data};
            if (wcnt == 2'd3) begin
                core_data <= {hold, bus.s_data};
            end
        end
    end

    // Valid tags shadow each block through the untagged core pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tags <= '0;
        end else begin
            tags <= {tags[CORE_LATENCY-1:0], issue};
        end
    end

    // Blocks owed to the output: in the core plus sitting in the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outst <= '0;
        end else begin
            unique case ({issue, pop})
                2'b10:   outst <= outst + 1'b1;
                2'b01:   outst <= outst - 1'b1;
                default: outst <= outst;
            endcase
        end
    end

    // Buffer write side: capture core output when its tag emerges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tail <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                ob[i] <= '0;
            end
        end else if (cap) begin
            ob[tail] <= core_out;
            tail     <= (tail == PTR_MAX) ? '0 : tail + 1'b1;
        end
    end

    // Buffer read side: step through words, retire block on last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            wptr <= 2'd0;
        end else if (m_acc) begin
            wptr <= wptr + 2'd1;
            if (pop) begin
                head <= (head == PTR_MAX) ? '0 : head + 1'b1;
            end
        end
    end

    // Buffer occupancy; a capture and a pop on one edge cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= '0;
        end else begin
            unique case ({cap, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Credit gating must make these impossible.
    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n) !(cap && buf_full)
    );
    a_credit_bound: assert property (
        @(posedge clk) disable iff (!rst_n) outst <= CNT_MAX
    );
    a_occ_le_outst: assert property (
        @(posedge clk) disable iff (!rst_n) occ <= outst
    );
    a_hold_stall: assert property (
        @(posedge clk) disable iff (!rst_n)
        (bus.m_valid && !bus.m_ready) |=>
        (bus.m_valid && $stable(bus.m_data) && $stable(bus.m_last))
    );
endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Directed bench for aes_stream_ctrl with a 10-stage stand-in core.
// The stand-in returns FIPS-197 ciphertexts for the two known vectors.
module tb_aes_stream_ctrl;
    localparam int LAT = 10;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] MIX = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] key_in;
    logic         key_we;
    logic         key_ready;
    logic [127:0] core_data;
    logic [127:0] core_key;
    logic [127:0] core_out;
    logic [127:0] pipe [LAT];

    aes_stream_ctrl_if bus ();

    aes_stream_ctrl #(
        .CORE_LATENCY(LAT),
        .OUT_DEPTH(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_in(key_in),
        .key_we(key_we),
        .key_ready(key_ready),
        .core_data(core_data),
        .core_key(core_key),
        .core_out(core_out),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] core_fn(
        input logic [127:0] d,
        input logic [127:0] k
    );
        if (k == K1 && d == P1) return C1;
        if (k == K2 && d == P2) return C2;
        return {d[95:0], d[127:96]} ^ k ^ MIX;
    endfunction

    function automatic logic [31:0] wsel(input logic [127:0] b, input int i);
        return b[127-32*i -: 32];
    endfunction

    // Stand-in core: 10 register stages, no valid.
    always @(posedge clk) begin
        pipe[0] <= core_fn(core_data, core_key);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign core_out = pipe[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int tmo = 0;
    int stall_bad = 0;
    logic [127:0] pts [80];
    logic [31:0] rx_d [$];
    bit          rx_l [$];
    int          rx_c [$];
    int          acc_c [$];

    // Black-box scoreboard of word count and outstanding blocks.
    bit mon_en = 1'b0;
    int mon_bad = 0;
    int mw = 0;
    int mo = 0;
    always begin
        @(negedge clk);
        #1;
        if (mon_en) begin
            if (key_ready !== (mw == 0 && mo == 0)) mon_bad++;
            if (bus.s_ready !== (mw != 3 || mo < 2)) mon_bad++;
            if (bus.m_valid && mo == 0) mon_bad++;
            if (bus.s_valid && bus.s_ready && mw == 3) mo++;
            if (bus.m_valid && bus.m_ready && bus.m_last) mo--;
            if (bus.s_valid && bus.s_ready) mw = (mw + 1) % 4;
        end
    end

    task automatic clear_q();
        rx_d.delete();
        rx_l.delete();
        rx_c.delete();
        acc_c.delete();
        stall_bad = 0;
    endtask

    task automatic load_key(input logic [127:0] k);
        key_in = k;
        key_we = 1'b1;
        @(negedge clk);
        key_we = 1'b0;
    endtask

    task automatic send_blocks(input int first, input int n, input bit gaps);
        int bud;
        for (int b = 0; b < n; b++) begin
            for (int w = 0; w < 4; w++) begin
                if (gaps && $urandom_range(0, 3) == 0) begin
                    bus.s_valid = 1'b0;
                    @(negedge clk);
                end
                bus.s_data  = wsel(pts[first+b], w);
                bus.s_valid = 1'b1;
                bud = 0;
                while (!bus.s_ready && bud < 2000) begin
                    @(negedge clk);
                    bud++;
                end
                if (bud >= 2000) tmo++;
                acc_c.push_back(cyc);
                @(negedge clk);
            end
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic recv_words(input int n, input bit rnd);
        int bud = 0;
        int got = 0;
        bit pstall = 1'b0;
        logic [31:0] pd = '0;
        logic pl = 1'b0;
        while (got < n && bud < 4000) begin
            bus.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pstall) begin
                if (!bus.m_valid || bus.m_data !== pd || bus.m_last !== pl)
                    stall_bad++;
            end
            pstall = bus.m_valid && !bus.m_ready;
            pd = bus.m_data;
            pl = bus.m_last;
            if (bus.m_valid && bus.m_ready) begin
                rx_d.push_back(bus.m_data);
                rx_l.push_back(bus.m_last);
                rx_c.push_back(cyc);
                got++;
            end
            @(negedge clk);
            bud++;
        end
        if (got < n) tmo++;
        bus.m_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (key_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_key_ready got %b want 1", key_ready);
        end
        checks++;
        if (bus.s_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_s_ready got %b want 0", bus.s_ready);
        end
        checks++;
        if ({bus.m_valid, bus.m_last, bus.m_data} !== 34'd0) begin
            errors++;
            $display("FAIL rst_m_out got %b %b %h want 0 0 0",
                     bus.m_valid, bus.m_last, bus.m_data);
        end
        checks++;
        if ({core_data, core_key} !== 256'd0) begin
            errors++;
            $display("FAIL rst_core got %h %h want 0", core_data, core_key);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.s_ready !== 1'b0) begin
            errors++;
            $display("FAIL rel_s_ready_early got %b want 0", bus.s_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL rel_s_ready got %b want 1", bus.s_ready);
        end
    endtask

    task automatic test_fips_k1();
        load_key(K1);
        checks++;
        if (core_key !== K1) begin
            errors++;
            $display("FAIL k1_load got %h want %h", core_key, K1);
        end
        clear_q();
        pts[0] = P1;
        send_blocks(0, 1, 1'b0);
        recv_words(4, 1'b0);
        for (int i = 0; i < 4 && i < rx_d.size(); i++) begin
            checks++;
            if (rx_d[i] !== wsel(C1, i) || rx_l[i] !== (i == 3)) begin
                errors++;
                $display("FAIL k1_word%0d got %h last %b want %h last %b",
                         i, rx_d[i], rx_l[i], wsel(C1, i), i == 3);
            end
        end
        checks++;
        if (rx_c.size() != 4 || rx_c[0] - acc_c[3] != LAT + 2) begin
            errors++;
            $display("FAIL k1_latency got %0d want %0d",
                     rx_c.size() ? rx_c[0] - acc_c[3] : -1, LAT + 2);
        end
    endtask

    task automatic test_key_lock();
        checks++;
        if (key_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_key_ready got %b want 1", key_ready);
        end
        load_key(K2);
        clear_q();
        pts[1] = P2;
        send_blocks(1, 1, 1'b0);
        checks++;
        if (key_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_key_ready got %b want 0", key_ready);
        end
        load_key(K1);
        checks++;
        if (core_key !== K2) begin
            errors++;
            $display("FAIL key_locked got %h want %h", core_key, K2);
        end
        recv_words(4, 1'b0);
        for (int i = 0; i < 4 && i < rx_d.size(); i++) begin
            checks++;
            if (rx_d[i] !== wsel(C2, i)) begin
                errors++;
                $display("FAIL k2_word%0d got %h want %h",
                         i, rx_d[i], wsel(C2, i));
            end
        end
        checks++;
        if (key_ready !== 1'b1) begin
            errors++;
            $display("FAIL drained_key_ready got %b want 1", key_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp;
        clear_q();
        pts[2] = 128'h00000001_00000002_00000003_00000004;
        pts[3] = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        pts[4] = 128'hffffffff_00000000_a5a5a5a5_5a5a5a5a;
        bus.m_ready = 1'b0;
        fork
            send_blocks(2, 3, 1'b0);
            begin
                repeat (40) @(negedge clk);
                checks++;
                if (acc_c.size() != 11) begin
                    errors++;
                    $display("FAIL bp_accepted got %0d want 11", acc_c.size());
                end
                checks++;
                if (bus.s_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_s_ready got %b want 0", bus.s_ready);
                end
                exp = core_fn(pts[2], K2);
                checks++;
                if (bus.m_valid !== 1'b1 || bus.m_data !== wsel(exp, 0)) begin
                    errors++;
                    $display("FAIL bp_head got %b %h want 1 %h",
                             bus.m_valid, bus.m_data, wsel(exp, 0));
                end
                recv_words(12, 1'b0);
            end
        join
        for (int i = 0; i < 12 && i < rx_d.size(); i++) begin
            exp = core_fn(pts[2+i/4], K2);
            checks++;
            if (rx_d[i] !== wsel(exp, i % 4)) begin
                errors++;
                $display("FAIL bp_word%0d got %h want %h",
                         i, rx_d[i], wsel(exp, i % 4));
            end
        end
        checks++;
        if (acc_c.size() != 12 || rx_c.size() < 4
            || acc_c[11] != rx_c[3] + 1) begin
            errors++;
            $display("FAIL bp_credit got %0d want %0d",
                     acc_c.size() == 12 ? acc_c[11] : -1,
                     rx_c.size() >= 4 ? rx_c[3] + 1 : -1);
        end
    endtask

    task automatic test_random_stall();
        logic [127:0] exp;
        int lasts = 0;
        clear_q();
        for (int b = 5; b < 13; b++)
            pts[b] = {$urandom, $urandom, $urandom, $urandom};
        fork
            send_blocks(5, 8, 1'b0);
            recv_words(32, 1'b1);
        join
        checks++;
        if (rx_d.size() != 32) begin
            errors++;
            $display("FAIL rs_count got %0d want 32", rx_d.size());
        end
        for (int i = 0; i < 32 && i < rx_d.size(); i++) begin
            exp = core_fn(pts[5+i/4], K2);
            if (rx_l[i]) lasts++;
            checks++;
            if (rx_d[i] !== wsel(exp, i % 4) || rx_l[i] !== (i % 4 == 3)) begin
                errors++;
                $display("FAIL rs_word%0d got %h last %b want %h last %b",
                         i, rx_d[i], rx_l[i], wsel(exp, i % 4), i % 4 == 3);
            end
        end
        checks++;
        if (lasts != 8) begin
            errors++;
            $display("FAIL rs_lasts got %0d want 8", lasts);
        end
        checks++;
        if (stall_bad != 0) begin
            errors++;
            $display("FAIL rs_stall_stable got %0d want 0", stall_bad);
        end
    endtask

    task automatic test_reset_mid();
        int bud = 0;
        int stale = 0;
        load_key(K1);
        clear_q();
        pts[13] = 128'h11111111_22222222_33333333_44444444;
        pts[14] = 128'h55555555_66666666_77777777_88888888;
        pts[15] = 128'h99999999_aaaaaaaa_bbbbbbbb_cccccccc;
        bus.m_ready = 1'b0;
        send_blocks(13, 1, 1'b0);
        while (!bus.m_valid && bud < 100) begin
            @(negedge clk);
            bud++;
        end
        checks++;
        if (bus.m_valid !== 1'b1) begin
            errors++;
            $display("FAIL rm_buffered got %b want 1", bus.m_valid);
        end
        send_blocks(14, 1, 1'b0);
        for (int w = 0; w < 2; w++) begin
            bus.s_data  = wsel(pts[15], w);
            bus.s_valid = 1'b1;
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.m_valid, bus.m_last, bus.m_data, bus.s_ready} !== 35'd0) begin
            errors++;
            $display("FAIL rm_outputs got %b %b %h %b want 0",
                     bus.m_valid, bus.m_last, bus.m_data, bus.s_ready);
        end
        checks++;
        if (key_ready !== 1'b1 || core_key !== '0 || core_data !== '0) begin
            errors++;
            $display("FAIL rm_core got %b %h %h want 1 0 0",
                     key_ready, core_key, core_data);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.m_ready = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (bus.m_valid) stale++;
        end
        bus.m_ready = 1'b0;
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL rm_stale got %0d want 0", stale);
        end
        load_key(K1);
        pts[16] = P1;
        send_blocks(16, 1, 1'b0);
        recv_words(4, 1'b0);
        for (int i = 0; i < 4 && i < rx_d.size(); i++) begin
            checks++;
            if (rx_d[i] !== wsel(C1, i)) begin
                errors++;
                $display("FAIL rm_word%0d got %h want %h",
                         i, rx_d[i], wsel(C1, i));
            end
        end
    endtask

    task automatic test_scoreboard();
        logic [127:0] exp;
        int lasts = 0;
        clear_q();
        for (int b = 17; b < 67; b++)
            pts[b] = {$urandom, $urandom, $urandom, $urandom};
        mw = 0;
        mo = 0;
        mon_bad = 0;
        mon_en = 1'b1;
        fork
            send_blocks(17, 50, 1'b1);
            recv_words(200, 1'b1);
        join
        @(negedge clk);
        mon_en = 1'b0;
        checks++;
        if (rx_d.size() != 200) begin
            errors++;
            $display("FAIL sb_count got %0d want 200", rx_d.size());
        end
        for (int i = 0; i < 200 && i < rx_d.size(); i++) begin
            exp = core_fn(pts[17+i/4], K1);
            if (rx_l[i]) lasts++;
            checks++;
            if (rx_d[i] !== wsel(exp, i % 4)) begin
                errors++;
                $display("FAIL sb_word%0d got %h want %h",
                         i, rx_d[i], wsel(exp, i % 4));
            end
        end
        checks++;
        if (lasts != 50) begin
            errors++;
            $display("FAIL sb_lasts got %0d want 50", lasts);
        end
        checks++;
        if (mon_bad != 0) begin
            errors++;
            $display("FAIL sb_counts got %0d want 0", mon_bad);
        end
        checks++;
        if (stall_bad != 0) begin
            errors++;
            $display("FAIL sb_stall_stable got %0d want 0", stall_bad);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        key_in      = '0;
        key_we      = 1'b0;
        bus.s_data  = '0;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        test_reset();
        test_fips_k1();
        test_key_lock();
        test_back_to_back();
        test_random_stall();
        test_reset_mid();
        test_scoreboard();
        checks++;
        if (tmo != 0) begin
            errors++;
            $display("FAIL timeouts got %0d want 0", tmo);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
